// File: rtl/ddr_burst_sched_pkg.sv
// Shared types and constants for the FIFO-to-AXI4 burst write scheduler.
package ddr_burst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] awsize_f(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/ddr_burst_sched_skid.sv
// Two-entry holding buffer between the FIFO read port and the AXI W channel.
module ddr_burst_sched_skid #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] head;
  logic [DW-1:0] tail;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // pop implies at least one entry, so count is 1 or 2 here
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign dout  = head;

endmodule

// File: rtl/ddr_burst_sched.sv
// Drains full bursts from a sync FIFO into AXI4 INCR writes over a circular DDR region.
// Optional short-burst flush is enabled with DDR_BURST_SCHED_FLUSH_EN.
//   state | meaning
//   IDLE  | waiting for a full burst (or flush) and enable
//   ADDR  | AW valid, address held stable
//   DATA  | streaming beats out of the skid buffer
//   RESP  | waiting for the write response
module ddr_burst_sched
  import ddr_burst_sched_pkg::*;
#(
  parameter int            DW        = 64,
  parameter int            AW        = 32,
  parameter int            FIFO_D    = 1024,
  parameter int            BURST_LEN = 16,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [AW-1:0] BUF_BYTES = 32'h0010_0000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
`ifdef DDR_BURST_SCHED_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          fifo_wr_accept,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic [AW-1:0] m_axi_awaddr,
  output logic [7:0]    m_axi_awlen,
  output logic [2:0]    m_axi_awsize,
  output logic [1:0]    m_axi_awburst,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [DW-1:0] m_axi_wdata,
  output logic          m_axi_wlast,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  input  logic [1:0]    m_axi_bresp,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready,
  output logic          busy,
  output logic          err,
  output logic [31:0]   burst_count
);

  localparam int            OCC_W       = $clog2(FIFO_D + 1);
  localparam int            LEN_W       = $clog2(BURST_LEN + 1);
  localparam logic [OCC_W-1:0] OCC_BURST = OCC_W'(BURST_LEN);
  localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_LEN * DW / 8);
  localparam logic [AW-1:0] END_ADDR    = BASE_ADDR + BUF_BYTES;

  state_e           state, state_nxt;
  logic [OCC_W-1:0] occ;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    addr_inc;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] pops;
  logic [LEN_W-1:0] beats;
  logic             rd_pend;
  logic             w_hs;
  logic             b_hs;
  logic [1:0]       skid_cnt;
  logic [1:0]       skid_held;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      len_q <= LEN_W'(BURST_LEN);
    end else begin
      state <= state_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    len_nxt       = len_q;
    m_axi_awvalid = 1'b0;
    m_axi_bready  = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable && occ >= OCC_BURST) begin
          state_nxt = ADDR;
          len_nxt   = LEN_W'(BURST_LEN);
        end
`ifdef DDR_BURST_SCHED_FLUSH_EN
        else if (enable && flush && occ != '0) begin
          state_nxt = ADDR;
          len_nxt   = LEN_W'(occ);
        end
`endif
      end
      ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = DATA;
      end
      DATA: begin
        if (w_hs && beats == len_q - LEN_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_hs = m_axi_wvalid & m_axi_wready;
  assign b_hs = m_axi_bvalid & m_axi_bready;

  // Room is judged after this cycle's W pop so a steady stream runs at one beat per cycle.
  assign skid_held  = skid_cnt - {1'b0, w_hs};
  assign fifo_rd_en = (state == DATA) && (pops < len_q) && (occ != '0)
                      && ((skid_held + {1'b0, rd_pend}) < 2'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ <= '0;
    end else begin
      case ({fifo_wr_accept, fifo_rd_en})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pops    <= '0;
      beats   <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= fifo_rd_en;
      if (state == IDLE) begin
        pops  <= '0;
        beats <= '0;
      end else begin
        if (fifo_rd_en) pops  <= pops + LEN_W'(1);
        if (w_hs)       beats <= beats + LEN_W'(1);
      end
    end
  end

  // Short flush bursts still consume a full slot so later bursts stay aligned.
  assign addr_inc = addr + BURST_BYTES;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr        <= BASE_ADDR;
      err         <= 1'b0;
      burst_count <= '0;
    end else if (b_hs) begin
      addr        <= (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
      burst_count <= burst_count + 32'd1;
      if (m_axi_bresp != AXI_RESP_OKAY) err <= 1'b1;
    end
  end

  ddr_burst_sched_skid #(.DW(DW)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .push   (rd_pend),
    .din    (fifo_dout),
    .pop    (w_hs),
    .valid  (m_axi_wvalid),
    .dout   (m_axi_wdata),
    .count  (skid_cnt)
  );

  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = 8'(len_q - LEN_W'(1));
  assign m_axi_awsize  = awsize_f(DW);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wlast   = m_axi_wvalid && (beats == len_q - LEN_W'(1));

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!resetn)
    fifo_rd_en |-> !fifo_empty);

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Randomized bench for ddr_burst_sched with a FIFO model, an AXI slave and a scoreboard.
module tb_ddr_burst_sched;

  localparam int          DW        = 64;
  localparam int          AW        = 32;
  localparam int          BL        = 16;
  localparam int          BYTES     = BL * DW / 8;
  localparam logic [31:0] BASE      = 32'h0;
  localparam logic [31:0] BUF_BYTES = 32'd256;
  localparam int          ERR_IDX   = 1;

  logic          clk, resetn, enable, fifo_wr_accept, fifo_rd_en, fifo_empty;
  logic [DW-1:0] fifo_dout, wr_data;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst, m_axi_bresp;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata;
  logic          m_axi_bvalid, m_axi_bready, busy, err;
  logic [31:0]   burst_count;

  int checks = 0;
  int failures = 0;

  ddr_burst_sched #(
    .DW(DW), .AW(AW), .FIFO_D(1024), .BURST_LEN(BL),
    .BASE_ADDR(BASE), .BUF_BYTES(BUF_BYTES)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo_wr_accept(fifo_wr_accept), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .busy(busy), .err(err),
    .burst_count(burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: one-cycle read latency, cleared together with the DUT.
  logic [DW-1:0] fq[$];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fq.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) fifo_dout <= fq.pop_front();
      if (fifo_wr_accept) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // AXI slave: ready generation and a B response two cycles after the last beat.
  bit rand_mode = 0;
  int b_idx = 0;
  initial begin
    bit last_hs, b_hs;
    int bdly;
    bdly = 0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      last_hs = resetn && m_axi_wvalid && m_axi_wready && m_axi_wlast;
      b_hs    = resetn && m_axi_bvalid && m_axi_bready;
      @(posedge clk);
      #1;
      if (!resetn) begin
        bdly = 0;
        m_axi_bvalid = 1'b0;
      end else begin
        if (b_hs) begin
          m_axi_bvalid = 1'b0;
          b_idx++;
        end
        if (last_hs) begin
          bdly = 1;
        end else if (bdly > 0) begin
          bdly--;
          if (bdly == 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_idx == ERR_IDX) ? 2'b10 : 2'b00;
          end
        end
      end
      m_axi_awready = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
      m_axi_wready  = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Scoreboard: expected data order, burst framing, addresses and counters.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_data[$];
  logic [31:0]   aw_log[$];
  int            aw_k = 0, beat = 0, m_bcount = 0, aw_hi = 0;
  bit            m_err = 0, p_wstall = 0, p_awstall = 0;
  logic [DW-1:0] p_wdata;
  logic [31:0]   p_awaddr;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      aw_k = 0; beat = 0; m_bcount = 0; m_err = 0;
      p_wstall = 0; p_awstall = 0;
    end else begin
      chk("burst_count", burst_count, 64'(m_bcount));
      chk("err", err, 64'(m_err));
      if (m_axi_awvalid || m_axi_wvalid || m_axi_bready) chk("busy", busy, 1);
      if (p_awstall) begin
        chk("aw_hold_valid", m_axi_awvalid, 1);
        chk("aw_hold_addr", m_axi_awaddr, p_awaddr);
      end
      if (p_wstall) begin
        chk("w_hold_valid", m_axi_wvalid, 1);
        chk("w_hold_data", m_axi_wdata, p_wdata);
      end
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_awvalid && m_axi_awready) begin
        chk("awaddr", m_axi_awaddr, 64'(BASE + (aw_k * BYTES) % BUF_BYTES));
        chk("awlen", m_axi_awlen, BL - 1);
        chk("awsize", m_axi_awsize, 3);
        chk("awburst", m_axi_awburst, 1);
        aw_log.push_back(m_axi_awaddr);
        aw_k++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_beat_has_word", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wdata", m_axi_wdata, exp_q.pop_front());
        chk("wlast", m_axi_wlast, beat == BL - 1);
        got_data.push_back(m_axi_wdata);
        beat = (beat + 1) % BL;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_bcount++;
        if (m_axi_bresp != 2'b00) m_err = 1;
      end
      p_awstall = m_axi_awvalid && !m_axi_awready;
      p_awaddr  = m_axi_awaddr;
      p_wstall  = m_axi_wvalid && !m_axi_wready;
      p_wdata   = m_axi_wdata;
    end
  end

  int seq = 0;
  task automatic write_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      fifo_wr_accept = 1'b1;
      wr_data = 64'(seq);
      exp_q.push_back(64'(seq));
      seq++;
      @(posedge clk); #1;
      fifo_wr_accept = 1'b0;
      if (gap > 0) repeat ($urandom_range(gap, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_bc(input int target, input int budget);
    int n = 0;
    while (burst_count != 32'(target) && n < budget) begin @(posedge clk); #1; n++; end
    chk("wait_burst_count", burst_count, 64'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int a0, n;
    resetn = 1'b0; enable = 1'b0; fifo_wr_accept = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_burst_count", burst_count, 0);
    chk("rst_awaddr", m_axi_awaddr, BASE);
    resetn = 1'b1;
    @(posedge clk); #1;

    // one full burst of 0..15
    enable = 1'b1;
    got_data.delete();
    write_n(BL, 0);
    wait_bc(1, 200);
    chk("p1_beats", got_data.size(), BL);
    chk("p1_first", got_data[0], 0);
    chk("p1_last", got_data[BL-1], BL - 1);
    chk("p1_addr", aw_log[0], 32'h0);
    chk("p1_err", err, 0);

    // one word short of a burst holds off AW; the 16th word starts it
    a0 = aw_hi;
    write_n(BL - 1, 0);
    repeat (50) begin @(posedge clk); #1; end
    chk("p2_no_aw", aw_hi, 64'(a0));
    write_n(1, 0);
    @(negedge clk);
    chk("p2_aw_not_early", m_axi_awvalid, 0);
    @(negedge clk);
    chk("p2_aw_next_cycle", m_axi_awvalid, 1);
    @(posedge clk); #1;
    wait_bc(2, 200);
    chk("p2_addr", aw_log[1], 32'h80);
    chk("p2_err_set", err, 1);

    // 64 words under random ready and write gaps
    rand_mode = 1;
    write_n(4 * BL, 3);
    wait_bc(6, 3000);
    chk("p3_addr2", aw_log[2], 32'h0);
    chk("p3_addr3", aw_log[3], 32'h80);
    chk("p3_addr4", aw_log[4], 32'h0);
    chk("p3_addr5", aw_log[5], 32'h80);
    chk("p3_err_sticky", err, 1);
    chk("p3_no_leftover", exp_q.size(), 0);

    // dropping enable mid-burst lets the burst finish
    rand_mode = 0;
    write_n(BL, 0);
    n = 0;
    while (!m_axi_awvalid && n < 100) begin @(posedge clk); #1; n++; end
    chk("p4_aw_seen", m_axi_awvalid, 1);
    enable = 1'b0;
    wait_bc(7, 300);
    repeat (2) begin @(posedge clk); #1; end
    chk("p4_idle", busy, 0);
    enable = 1'b1;

    // reset in the middle of the data phase
    rand_mode = 1;
    write_n(BL, 0);
    n = 0;
    while (!(m_axi_wvalid && beat >= 3) && n < 500) begin @(posedge clk); #1; n++; end
    chk("p5_in_data", m_axi_wvalid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("p5_awvalid", m_axi_awvalid, 0);
    chk("p5_wvalid", m_axi_wvalid, 0);
    chk("p5_wlast", m_axi_wlast, 0);
    chk("p5_bready", m_axi_bready, 0);
    chk("p5_rd_en", fifo_rd_en, 0);
    chk("p5_busy", busy, 0);
    chk("p5_err", err, 0);
    chk("p5_burst_count", burst_count, 0);
    chk("p5_pre_addr", aw_log[7], 32'h80);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    rand_mode = 0;
    @(posedge clk); #1;
    write_n(BL, 0);
    wait_bc(1, 300);
    chk("p5_base_addr", aw_log[aw_log.size()-1], BASE);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
